rf_param: RTL
=============

Name: rf_param

Overview:
- Parametrised successor to the single-issue 32x32 MIPS register file.
- Configurable data width and register count.
- Two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- A bulk-clear sequencer zeroes the whole file one entry per cycle, with a Busy handshake.
- Sits between decode (RA/RB) and writeback (RW/BusW) in the datapath; the ALU consumes BusA/BusB.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; register count DEPTH = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- RegWr  input  1  write enable, sampled at posedge Clk.
- RW  input  ADDR_W  write address.
- BusW  input  DATA_W  write data.
- RA  input  ADDR_W  read address, port A.
- RB  input  ADDR_W  read address, port B.
- BusA  output  DATA_W  read data, port A (combinational).
- BusB  output  DATA_W  read data, port B (combinational).
- Clr  input  1  single-cycle request to start a bulk clear.
- Busy  output  1  high while the bulk clear is in progress.

Behaviour:
- Reset:
  - Rst_n low asynchronously zeroes all DEPTH registers.
  - FSM forced to IDLE; clear counter to 0; Busy=0.
  - BusA/BusB therefore read 0 while reset is asserted.
  - Reset mid-clear aborts the clear; every register ends at 0.
- Write:
  - At posedge Clk with RegWr=1 and Busy=0, mem[RW] <= BusW.
  - With ZERO_REG=1 and RW=0 the write is dropped.
  - Write latency: 1 cycle (value visible on the array after the edge).
- Read:
  - BusA = mem[RA] and BusB = mem[RB], combinational with zero latency.
  - With ZERO_REG=1, address 0 always reads 0.
  - Both ports may address the same register.
- FSM states:
  - IDLE: Busy=0. Clr=1 at posedge -> CLEAR, counter <= 0.
  - CLEAR: Busy=1. Each posedge: mem[counter] <= 0, counter <= counter+1.
  - When counter = DEPTH-1 the clear completes -> IDLE, so Busy stays high exactly DEPTH cycles.
  - Counter is ADDR_W bits and wraps naturally; the wrap is never observed because the FSM exits first.
- Simultaneous and boundary events:
  - Clr and RegWr in the same IDLE cycle: the write commits this edge, and clearing starts next edge (it will later zero that entry).
  - RegWr while Busy=1 is silently dropped; the writeback stage must stall on Busy.
  - Clr while Busy=1 is ignored; no restart and no extension.
  - Reads during CLEAR return current array contents: entries below counter read 0, others hold their old values.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined:
  - If RegWr=1, Busy=0 and RW==RA, BusA = BusW in the same cycle (write-to-read forwarding); likewise for BusB.
  - Suppressed for RW=0 when ZERO_REG=1.
- Undefined: reads return the pre-edge array value; the new value is visible the cycle after the write edge.

Decomposition:
- Package rf_pkg:
  - FSM state typedef (RF_IDLE, RF_CLEAR).
  - Default constants RF_DATA_W=32 and RF_ADDR_W=5.
- Sub-module rf_clear_seq:
  - Contains the FSM and counter.
  - Outputs Busy, clr_we and clr_addr to the array.
  - The top module muxes the array write port between writeback and the clear sequencer.

Test Plan:
1. Reset then read every address -> BusA=BusB=0 for all 32 registers.
2. Write 0xDEADBEEF to r5 at edge N; RA=5 after edge N -> BusA=0xDEADBEEF. Write 0x1234 to r0 -> RA=0 reads 0.
3. RegWr=1, RW=RA=7, BusW=0xA5A5A5A5 in one cycle:
   - With RF_WR_BYPASS_EN, BusA=0xA5A5A5A5 before the edge.
   - Without it, BusA shows the old value until after the edge.
4. Fill r1..r31 with their own index. Pulse Clr -> Busy high exactly 32 cycles. Afterwards all reads are 0. Mid-clear (cycle 10), r20 still reads 20 and r3 reads 0.
5. RegWr to r9 with 0x55 during Busy -> r9 reads 0 after the clear. Second Clr pulse during Busy -> Busy length still 32.
6. Drop Rst_n asynchronously at clear cycle 5 -> Busy=0 immediately, all registers 0. A Clr after release restarts a full 32-cycle clear.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and defaults for the parametrised register file.
//   rf_state_e : bulk-clear sequencer states
//   RF_DATA_W  : default register width
//   RF_ADDR_W  : default address width (DEPTH = 2**RF_ADDR_W)
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer for rf_param: walks every register address once, one per cycle.
// Ports:
//   clk_i      : rising-edge clock
//   rst_ni     : asynchronous active-low reset
//   clr_i      : single-cycle request to start a clear (ignored while busy)
//   busy_o     : high for exactly 2**ADDR_W cycles while clearing
//   clr_we_o   : array write enable (write zero) driven by the sequencer
//   clr_addr_o : array address being cleared this cycle
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    if (clr_i) begin
                        state_q <= RF_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // Counter wraps to 0 on the final step, harmless since we leave CLEAR.
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == LastAddr) begin
                        state_q <= RF_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RF_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/rf_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero register 0, and a one-entry-per-cycle bulk clear.
// Ports:
//   Clk, Rst_n     : clock, asynchronous active-low reset (zeroes the whole array)
//   RegWr, RW, BusW: writeback port; dropped while Busy
//   RA/BusA, RB/BusB: combinational read ports
//   Clr            : start bulk clear;  Busy : clear in progress
// Build option: define RF_WR_BYPASS_EN to forward BusW to a read port whose address
// matches an accepted write in the same cycle.
module rf_param
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] BusW,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    input  logic              Clr,
    output logic              Busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wb_we;

    rf_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clk_i     (Clk),
        .rst_ni    (Rst_n),
        .clr_i     (Clr),
        .busy_o    (Busy),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    // Writeback is accepted only when idle; writes to r0 vanish when it is hardwired.
    assign wb_we = RegWr && !Busy && !(ZERO_REG && (RW == '0));

    // Sequencer owns the write port while Busy.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wb_we) begin
            mem_q[RW] <= BusW;
        end
    end

    always_comb begin
        BusA = mem_q[RA];
        if (ZERO_REG && (RA == '0)) begin
            BusA = '0;
`ifdef RF_WR_BYPASS_EN
        end else if (wb_we && (RW == RA)) begin
            BusA = BusW;
`endif
        end
    end

    always_comb begin
        BusB = mem_q[RB];
        if (ZERO_REG && (RB == '0)) begin
            BusB = '0;
`ifdef RF_WR_BYPASS_EN
        end else if (wb_we && (RW == RB)) begin
            BusB = BusW;
`endif
        end
    end

endmodule
